// File: rtl/trace_check_sink.sv
// Expected-vs-actual checker: per-channel expectation FIFOs popped by a DUT stream,
// with optional LFSR backpressure, first-mismatch reporting and a saturating error count.
module trace_check_sink #(
   parameter int unsigned p_num_chans = 2,
   parameter int unsigned p_msg_bits  = 32,
   parameter int unsigned p_depth     = 16,
   parameter bit          p_stall_en  = 1'b0,
   parameter logic [7:0]  p_seed      = 8'hA5,
   localparam int unsigned ChanW      = (p_num_chans > 1) ? $clog2(p_num_chans) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              load_val,
   input  logic [ChanW-1:0]                  load_chan,
   input  logic [p_msg_bits-1:0]             load_msg,
   output logic                              load_rdy,
   input  logic [p_num_chans-1:0]            dut_val,
   input  logic [p_num_chans*p_msg_bits-1:0] dut_msg,
   output logic [p_num_chans-1:0]            dut_rdy,
   output logic                              err_val,
   output logic [ChanW-1:0]                  err_chan,
   output logic [p_msg_bits-1:0]             err_exp,
   output logic [p_msg_bits-1:0]             err_act,
   output logic [15:0]                       err_count,
   output logic                              done
);
   localparam int unsigned PtrW = $clog2(p_depth);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned SumW = 17;

   logic [p_msg_bits-1:0]  mem_q    [p_num_chans][p_depth];
   logic [PtrW-1:0]        wr_ptr_q [p_num_chans];
   logic [PtrW-1:0]        wr_ptr_d [p_num_chans];
   logic [PtrW-1:0]        rd_ptr_q [p_num_chans];
   logic [PtrW-1:0]        rd_ptr_d [p_num_chans];
   logic [CntW-1:0]        cnt_q    [p_num_chans];
   logic [CntW-1:0]        cnt_d    [p_num_chans];
   logic [7:0]             lfsr_q, lfsr_d;
   logic                   err_val_q, err_val_d;
   logic [ChanW-1:0]       err_chan_q, err_chan_d;
   logic [p_msg_bits-1:0]  err_exp_q, err_exp_d;
   logic [p_msg_bits-1:0]  err_act_q, err_act_d;
   logic [15:0]            err_count_q, err_count_d;

   logic [p_num_chans-1:0] full_c, empty_c, stall_c, push_c, pop_c, mism_c;
   logic [p_msg_bits-1:0]  head_c [p_num_chans];
   logic [p_msg_bits-1:0]  act_c  [p_num_chans];
   logic                   load_sel_rdy_c;
   logic [3:0]             n_mism_c;
   logic [SumW-1:0]        err_sum_c;

   // Channel status from registered occupancy; no same-cycle pop credit for loads.
   always_comb begin
      full_c         = '0;
      empty_c        = '0;
      stall_c        = '0;
      load_sel_rdy_c = 1'b0;
      head_c         = '{default: '0};
      act_c          = '{default: '0};
      for (int i = 0; i < int'(p_num_chans); i++) begin
         full_c[i]  = (cnt_q[i] == CntW'(p_depth));
         empty_c[i] = (cnt_q[i] == '0);
         stall_c[i] = p_stall_en & lfsr_q[3'(i % 8)];
         head_c[i]  = mem_q[i][rd_ptr_q[i]];
         act_c[i]   = dut_msg[i*int'(p_msg_bits) +: p_msg_bits];
         if (load_chan == ChanW'(i)) begin
            load_sel_rdy_c = ~full_c[i];
         end
      end
   end

   assign load_rdy = ~rst & load_sel_rdy_c;
   assign dut_rdy  = {p_num_chans{~rst}} & ~empty_c & ~stall_c;
   assign done     = rst | (&empty_c);

   // Per-channel transfers, compare at pop, pointer/occupancy next state.
   always_comb begin
      push_c   = '0;
      pop_c    = '0;
      mism_c   = '0;
      n_mism_c = '0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < int'(p_num_chans); i++) begin
         push_c[i]   = load_val & load_rdy & (load_chan == ChanW'(i));
         pop_c[i]    = dut_val[i] & dut_rdy[i];
         mism_c[i]   = pop_c[i] & (act_c[i] != head_c[i]);
         n_mism_c    = n_mism_c + 4'(mism_c[i]);
         wr_ptr_d[i] = wr_ptr_q[i] + PtrW'(push_c[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + PtrW'(pop_c[i]);
         cnt_d[i]    = cnt_q[i] + CntW'(push_c[i]) - CntW'(pop_c[i]);
      end
   end

   // Error report: lowest-indexed mismatch wins, detail holds when idle.
   always_comb begin
      err_val_d  = |mism_c;
      err_chan_d = err_chan_q;
      err_exp_d  = err_exp_q;
      err_act_d  = err_act_q;
      for (int i = int'(p_num_chans) - 1; i >= 0; i--) begin
         if (mism_c[i]) begin
            err_chan_d = ChanW'(i);
            err_exp_d  = head_c[i];
            err_act_d  = act_c[i];
         end
      end
      err_sum_c   = SumW'(err_count_q) + SumW'(n_mism_c);
      err_count_d = err_sum_c[16] ? 16'hFFFF : err_sum_c[15:0];
      lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '{default: '0};
         rd_ptr_q    <= '{default: '0};
         cnt_q       <= '{default: '0};
         lfsr_q      <= p_seed;
         err_val_q   <= 1'b0;
         err_chan_q  <= '0;
         err_exp_q   <= '0;
         err_act_q   <= '0;
         err_count_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         lfsr_q      <= lfsr_d;
         err_val_q   <= err_val_d;
         err_chan_q  <= err_chan_d;
         err_exp_q   <= err_exp_d;
         err_act_q   <= err_act_d;
         err_count_q <= err_count_d;
      end
   end

   // Expectation storage needs no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(p_num_chans); i++) begin
         if (push_c[i]) begin
            mem_q[i][wr_ptr_q[i]] <= load_msg;
         end
      end
   end

   assign err_val   = err_val_q;
   assign err_chan  = err_chan_q;
   assign err_exp   = err_exp_q;
   assign err_act   = err_act_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_trace_check_sink.sv
// Bench for trace_check_sink: directed vectors on a no-stall instance with an error-report
// scoreboard, plus an LFSR-backpressure instance checked against a cycle model.
module tb_trace_check_sink;
   localparam int NC      = 2;
   localparam int W       = 32;
   localparam int D       = 16;
   localparam int N_STALL = 50;

   typedef struct packed {
      logic [0:0]   chan;
      logic [W-1:0] exp_msg;
      logic [W-1:0] act_msg;
      logic [15:0]  cnt;
   } err_rec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_a, load_val_a, load_rdy_a, err_val_a, done_a;
   logic [0:0]      load_chan_a, err_chan_a;
   logic [W-1:0]    load_msg_a, err_exp_a, err_act_a;
   logic [NC-1:0]   dut_val_a, dut_rdy_a;
   logic [NC*W-1:0] dut_msg_a;
   logic [15:0]     err_count_a;

   logic            rst_b, load_val_b, load_rdy_b, err_val_b, done_b;
   logic [0:0]      load_chan_b, err_chan_b;
   logic [W-1:0]    load_msg_b, err_exp_b, err_act_b;
   logic [NC-1:0]   dut_val_b, dut_rdy_b;
   logic [NC*W-1:0] dut_msg_b;
   logic [15:0]     err_count_b;

   trace_check_sink #(.p_num_chans(NC), .p_msg_bits(W), .p_depth(D),
                      .p_stall_en(1'b0), .p_seed(8'hA5)) u_dut_a (
      .clk(clk), .rst(rst_a), .load_val(load_val_a), .load_chan(load_chan_a),
      .load_msg(load_msg_a), .load_rdy(load_rdy_a), .dut_val(dut_val_a),
      .dut_msg(dut_msg_a), .dut_rdy(dut_rdy_a), .err_val(err_val_a),
      .err_chan(err_chan_a), .err_exp(err_exp_a), .err_act(err_act_a),
      .err_count(err_count_a), .done(done_a));

   trace_check_sink #(.p_num_chans(NC), .p_msg_bits(W), .p_depth(D),
                      .p_stall_en(1'b1), .p_seed(8'hA5)) u_dut_b (
      .clk(clk), .rst(rst_b), .load_val(load_val_b), .load_chan(load_chan_b),
      .load_msg(load_msg_b), .load_rdy(load_rdy_b), .dut_val(dut_val_b),
      .dut_msg(dut_msg_b), .dut_rdy(dut_rdy_b), .err_val(err_val_b),
      .err_chan(err_chan_b), .err_exp(err_exp_b), .err_act(err_act_b),
      .err_count(err_count_b), .done(done_b));

   int       errors = 0;
   int       checks = 0;
   int       exp_cnt = 0;
   err_rec_t exp_q[$];

   int         occ[NC];
   int         sent[NC];
   int         acc[NC];
   int         ld_c, pick, toggles, c;
   logic [7:0] lfsr_m;
   logic [NC-1:0] rdy_m, rdy_prev;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [W-1:0] msg(input int ch, input int k);
      return 32'hC000_0000 | (32'(ch) << 16) | 32'(k);
   endfunction

   task automatic idle_a();
      load_val_a = 1'b0; load_chan_a = '0; load_msg_a = '0;
      dut_val_a = '0; dut_msg_a = '0;
   endtask

   task automatic idle_b();
      load_val_b = 1'b0; load_chan_b = '0; load_msg_b = '0;
      dut_val_b = '0; dut_msg_b = '0;
   endtask

   task automatic load_a(input int ch, input logic [W-1:0] m);
      load_val_a = 1'b1; load_chan_a = 1'(ch); load_msg_a = m;
      #1 check("load_rdy_accept", 64'(load_rdy_a), 64'd1);
      cyc();
      load_val_a = 1'b0;
   endtask

   // Present one DUT message; a mismatch against the bench's known head queues an error record.
   task automatic send_a(input int ch, input logic [W-1:0] m, input logic [W-1:0] head);
      dut_val_a = '0;
      dut_val_a[ch] = 1'b1;
      dut_msg_a[ch*W +: W] = m;
      if (m != head) begin
         exp_cnt++;
         exp_q.push_back('{chan: 1'(ch), exp_msg: head, act_msg: m, cnt: 16'(exp_cnt)});
      end
      #1 check("dut_rdy_pop", 64'(dut_rdy_a[ch]), 64'd1);
      cyc();
      dut_val_a = '0;
      check("err_val_timing", 64'(err_val_a), 64'(m != head));
   endtask

   // Scoreboard monitor: every error pulse must match the oldest queued expectation.
   always @(negedge clk) begin : mon_a
      err_rec_t rec;
      if (err_val_a === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL err_pulse_a: unexpected pulse chan=%0d exp=%h act=%h cnt=%0d, required no pulse",
                     err_chan_a, err_exp_a, err_act_a, err_count_a);
         end else begin
            rec = exp_q.pop_front();
            if ({err_chan_a, err_exp_a, err_act_a, err_count_a} !==
                {rec.chan, rec.exp_msg, rec.act_msg, rec.cnt}) begin
               errors++;
               $display("FAIL err_report_a: got chan=%0d exp=%h act=%h cnt=%0d, required chan=%0d exp=%h act=%h cnt=%0d",
                        err_chan_a, err_exp_a, err_act_a, err_count_a,
                        rec.chan, rec.exp_msg, rec.act_msg, rec.cnt);
            end
         end
      end
   end

   always @(negedge clk) begin : mon_b
      if (err_val_b === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL err_pulse_b: got chan=%0d exp=%h act=%h, required no pulse",
                  err_chan_b, err_exp_b, err_act_b);
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      rst_a = 1'b1; rst_b = 1'b1;
      idle_a(); idle_b();
      cyc(); cyc();

      // Reset: outputs forced, loads and DUT traffic ignored
      load_val_a = 1'b1; load_msg_a = 32'h99; dut_val_a = '1;
      #1;
      check("rst_load_rdy", 64'(load_rdy_a), 64'd0);
      check("rst_dut_rdy", 64'(dut_rdy_a), 64'd0);
      check("rst_done", 64'(done_a), 64'd1);
      check("rst_err_count", 64'(err_count_a), 64'd0);
      check("rst_err_val", 64'(err_val_a), 64'd0);
      check("rst_err_exp", 64'(err_exp_a), 64'd0);
      check("rst_err_act", 64'(err_act_a), 64'd0);
      cyc();
      idle_a(); rst_a = 1'b0;
      #1 check("post_rst_done", 64'(done_a), 64'd1);
      @(negedge clk);

      // Single matching transfer, no bypass on the load cycle
      load_val_a = 1'b1; load_chan_a = 1'b0; load_msg_a = 32'h5;
      dut_val_a = 2'b01; dut_msg_a[0 +: W] = 32'h5;
      #1 check("no_bypass", 64'(dut_rdy_a[0]), 64'd0);
      check("load_rdy_empty", 64'(load_rdy_a), 64'd1);
      cyc();
      load_val_a = 1'b0;
      #1 check("occupied_done", 64'(done_a), 64'd0);
      check("rdy_after_load", 64'(dut_rdy_a[0]), 64'd1);
      cyc();
      dut_val_a = '0;
      check("match_done", 64'(done_a), 64'd1);
      check("match_err_count", 64'(err_count_a), 64'd0);

      // Mismatch on ch1, then detail must hold after the pulse
      load_a(1, 32'hA);
      send_a(1, 32'hB, 32'hA);
      check("err_count_one", 64'(err_count_a), 64'd1);
      cyc();
      check("hold_err_val", 64'(err_val_a), 64'd0);
      check("hold_err_chan", 64'(err_chan_a), 64'd1);
      check("hold_err_exp", 64'(err_exp_a), 64'hA);
      check("hold_err_act", 64'(err_act_a), 64'hB);

      // DUT traffic on an empty channel is held off
      dut_val_a = 2'b10; dut_msg_a[W +: W] = 32'hDEAD;
      for (int k = 0; k < 3; k++) begin
         #1 check("empty_held_off", 64'(dut_rdy_a[1]), 64'd0);
         cyc();
      end
      idle_a();
      check("empty_no_err", 64'(err_count_a), 64'(exp_cnt));

      // Fill ch0, pop+load when full, then wrap and drain in order
      for (int k = 0; k < D; k++) load_a(0, 32'h100 + 32'(k));
      load_val_a = 1'b1; load_chan_a = 1'b0; load_msg_a = 32'h200;
      dut_val_a = 2'b01; dut_msg_a[0 +: W] = 32'h100;
      #1 check("full_pop_load_rdy", 64'(load_rdy_a), 64'd0);
      check("full_not_done", 64'(done_a), 64'd0);
      cyc();
      dut_val_a = '0;
      #1 check("after_pop_load_rdy", 64'(load_rdy_a), 64'd1);
      cyc();
      load_val_a = 1'b0;
      #1 check("refull_load_rdy", 64'(load_rdy_a), 64'd0);
      @(negedge clk);
      for (int k = 1; k < D; k++) send_a(0, 32'h100 + 32'(k), 32'h100 + 32'(k));
      send_a(0, 32'h200, 32'h200);
      check("wrap_done", 64'(done_a), 64'd1);
      check("wrap_err_count", 64'(err_count_a), 64'(exp_cnt));

      // Both channels mismatch together: lowest channel reported, count +2
      load_a(0, 32'h11);
      load_a(1, 32'h22);
      dut_val_a = 2'b11; dut_msg_a = {32'h23, 32'h12};
      exp_cnt += 2;
      exp_q.push_back('{chan: 1'b0, exp_msg: 32'h11, act_msg: 32'h12, cnt: 16'(exp_cnt)});
      #1 check("dual_rdy", 64'(dut_rdy_a), 64'd3);
      cyc();
      idle_a();
      check("dual_err_count", 64'(err_count_a), 64'(exp_cnt));

      // A later matching transfer leaves the report untouched
      load_a(1, 32'h77);
      send_a(1, 32'h77, 32'h77);
      check("match_keeps_chan", 64'(err_chan_a), 64'd0);
      check("match_keeps_exp", 64'(err_exp_a), 64'h11);
      check("match_keeps_act", 64'(err_act_a), 64'h12);

      // Reset mid-operation with entries queued and a pulse showing
      load_a(0, 32'h31); load_a(0, 32'h32); load_a(0, 32'h33);
      load_a(1, 32'h40);
      send_a(1, 32'h41, 32'h40);
      check("queued_not_done", 64'(done_a), 64'd0);
      rst_a = 1'b1;
      cyc();
      check("midrst_err_val", 64'(err_val_a), 64'd0);
      check("midrst_err_count", 64'(err_count_a), 64'd0);
      check("midrst_done", 64'(done_a), 64'd1);
      check("midrst_err_exp", 64'(err_exp_a), 64'd0);
      rst_a = 1'b0; exp_cnt = 0;
      cyc();
      check("postrst_done", 64'(done_a), 64'd1);
      check("postrst_load_rdy", 64'(load_rdy_a), 64'd1);
      check("sb_drained", 64'(exp_q.size()), 64'd0);

      // Backpressure instance against a cycle model of occupancy and the LFSR
      rst_b = 1'b0;
      lfsr_m = 8'hA5; toggles = 0; pick = 0; rdy_prev = '0;
      for (int i = 0; i < NC; i++) begin occ[i] = 0; sent[i] = 0; acc[i] = 0; end
      for (int n = 0; n < 3000; n++) begin
         if (acc[0] == N_STALL && acc[1] == N_STALL) break;
         ld_c = -1;
         for (int j = 0; j < NC; j++) begin
            c = (pick + j) % NC;
            if (ld_c < 0 && sent[c] < N_STALL && occ[c] < D) ld_c = c;
         end
         idle_b();
         if (ld_c >= 0) begin
            load_val_b = 1'b1; load_chan_b = 1'(ld_c); load_msg_b = msg(ld_c, sent[ld_c]);
         end
         for (int i = 0; i < NC; i++) begin
            dut_val_b[i] = (acc[i] < N_STALL);
            dut_msg_b[i*W +: W] = msg(i, acc[i]);
            rdy_m[i] = (occ[i] != 0) && !lfsr_m[i];
         end
         if (rdy_m != rdy_prev) toggles++;
         rdy_prev = rdy_m;
         #1 check("stall_dut_rdy", 64'(dut_rdy_b), 64'(rdy_m));
         if (load_val_b) check("stall_load_rdy", 64'(load_rdy_b), 64'd1);
         @(posedge clk);
         for (int i = 0; i < NC; i++) begin
            if (dut_val_b[i] && rdy_m[i]) begin acc[i]++; occ[i]--; end
         end
         if (ld_c >= 0) begin sent[ld_c]++; occ[ld_c]++; end
         lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
         pick = 1 - pick;
         @(negedge clk);
      end
      idle_b();
      check("stall_accepted_ch0", 64'(acc[0]), 64'(N_STALL));
      check("stall_accepted_ch1", 64'(acc[1]), 64'(N_STALL));
      cyc();
      check("stall_err_count", 64'(err_count_b), 64'd0);
      check("stall_done", 64'(done_b), 64'd1);
      check("stall_rdy_toggles", 64'(toggles >= 4), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
